// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH independent up/down event counters with sticky overflow flags and a
// registered read port. Optional macro PERF_CNT_SNAPSHOT_EN adds atomic shadow capture.
module perf_counter_bank #(
    parameter int NUM_CH   = 8,
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] cnt_clear,
    input  logic [NUM_CH-1:0] cnt_inc,
    input  logic [NUM_CH-1:0] cnt_dec,
    input  logic [NUM_CH-1:0] ovf_clear,
    input  logic              rd_en,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] ovf_flag
`ifdef PERF_CNT_SNAPSHOT_EN
    ,
    input  logic              snap_req
`endif
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt     [NUM_CH];
    logic [WIDTH:0]   step_p0 [NUM_CH];
    logic [WIDTH-1:0] rd_mux_p0;

    // Returns {overflow_event, next_value}; inc and dec together cancel out.
    function automatic logic [WIDTH:0] step_cnt(input logic [WIDTH-1:0] cur,
                                                input logic up, input logic dn);
        logic [WIDTH-1:0] nxt;
        logic             ovf;
        nxt = cur;
        ovf = 1'b0;
        if (up && !dn) begin
            if (&cur) begin
                ovf = 1'b1;
                nxt = (SATURATE != 0) ? cur : '0;
            end else begin
                nxt = cur + ONE;
            end
        end else if (dn && !up) begin
            if (cur == '0) begin
                ovf = 1'b1;
                nxt = (SATURATE != 0) ? '0 : '1;
            end else begin
                nxt = cur - ONE;
            end
        end
        return {ovf, nxt};
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            step_p0[i] = step_cnt(cnt[i], cnt_inc[i], cnt_dec[i]);
        end
    end

    // Counter and flag update: clear beats inc/dec, a new overflow beats ovf_clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            ovf_flag <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cnt_clear[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= step_p0[i][WIDTH-1:0];
                end
                if (!cnt_clear[i] && step_p0[i][WIDTH]) begin
                    ovf_flag[i] <= 1'b1;
                end else if (ovf_clear[i]) begin
                    ovf_flag[i] <= 1'b0;
                end
            end
        end
    end

`ifdef PERF_CNT_SNAPSHOT_EN
    logic [WIDTH-1:0] shadow [NUM_CH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
        end else if (snap_req) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= cnt[i];
            end
        end
    end
`endif

    // Read select; out-of-range channels fall through to zero.
    always_comb begin
        rd_mux_p0 = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
`ifdef PERF_CNT_SNAPSHOT_EN
                rd_mux_p0 = shadow[i];
`else
                rd_mux_p0 = cnt[i];
`endif
            end
        end
    end

    // Read stage boundary: p0 select -> registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux_p0;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a wrapping and a saturating instance share stimulus;
// read results are scoreboarded against hand-derived expectations.
module tb_perf_counter_bank;

    localparam int NCH = 6;
    localparam int W   = 4;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] cnt_clear, cnt_inc, cnt_dec, ovf_clear;
    logic           rd_en;
    logic [2:0]     rd_sel;
    logic           snap_req;
    logic [W-1:0]   rd_data_w, rd_data_s;
    logic           rd_valid_w, rd_valid_s;
    logic [NCH-1:0] ovf_w, ovf_s;

    perf_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .cnt_clear(cnt_clear), .cnt_inc(cnt_inc),
        .cnt_dec(cnt_dec), .ovf_clear(ovf_clear), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data_w), .rd_valid(rd_valid_w), .ovf_flag(ovf_w)
`ifdef PERF_CNT_SNAPSHOT_EN
        , .snap_req(snap_req)
`endif
    );

    perf_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .cnt_clear(cnt_clear), .cnt_inc(cnt_inc),
        .cnt_dec(cnt_dec), .ovf_clear(ovf_clear), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data_s), .rd_valid(rd_valid_s), .ovf_flag(ovf_s)
`ifdef PERF_CNT_SNAPSHOT_EN
        , .snap_req(snap_req)
`endif
    );

    typedef struct {
        logic [W-1:0] w;
        logic [W-1:0] s;
    } exp_t;

    typedef struct {
        int             ch;
        bit             oclr;
        bit             clr;
        int             ninc;
        int             ndec;
        int             rsel;
        logic [W-1:0]   ew;
        logic [W-1:0]   es;
        logic [NCH-1:0] ovw;
        logic [NCH-1:0] ovs;
    } vec_t;

    exp_t         sbq[$];
    logic [W-1:0] last_w, last_s;
    int           errors = 0;
    int           checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock; strobes are single-cycle, then the read scoreboard is checked.
    task automatic tick();
        bit   pend;
        bit   was_rst;
        exp_t e;
        pend    = rd_en && !reset;
        was_rst = reset;
        @(posedge clk);
        #1;
        cnt_clear = '0; cnt_inc = '0; cnt_dec = '0; ovf_clear = '0;
        rd_en = 1'b0; reset = 1'b0; snap_req = 1'b0;
        if (was_rst) begin
            last_w = '0;
            last_s = '0;
        end
        if (pend) begin
            if (sbq.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rd_valid_wrap", rd_valid_w, 1);
                chk("rd_valid_sat", rd_valid_s, 1);
                chk("rd_data_wrap", rd_data_w, e.w);
                chk("rd_data_sat", rd_data_s, e.s);
                last_w = e.w;
                last_s = e.s;
            end
        end else begin
            chk("rd_valid_idle_wrap", rd_valid_w, 0);
            chk("rd_valid_idle_sat", rd_valid_s, 0);
            chk("rd_data_hold_wrap", rd_data_w, last_w);
            chk("rd_data_hold_sat", rd_data_s, last_s);
        end
    endtask

    task automatic issue_read(input int sel, input logic [W-1:0] ew,
                              input logic [W-1:0] es, input bit autosnap);
`ifdef PERF_CNT_SNAPSHOT_EN
        if (autosnap) begin
            snap_req = 1'b1;
            tick();
        end
`endif
        rd_en  = 1'b1;
        rd_sel = 3'(sel);
        if (!reset) sbq.push_back('{w: ew, s: es});
    endtask

    task automatic chk_ovf(input logic [NCH-1:0] ew, input logic [NCH-1:0] es);
        chk("ovf_flag_wrap", ovf_w, ew);
        chk("ovf_flag_sat", ovf_s, es);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{0, 0, 0, 16, 0, 0, 4'd0,  4'd15, 6'h01, 6'h01};
        tbl[1] = '{0, 0, 0, 0,  1, 0, 4'd15, 4'd14, 6'h01, 6'h01};
        tbl[2] = '{1, 0, 0, 20, 0, 1, 4'd4,  4'd15, 6'h03, 6'h03};
        tbl[3] = '{1, 1, 0, 0,  0, 1, 4'd4,  4'd15, 6'h01, 6'h01};
        tbl[4] = '{0, 1, 1, 0,  0, 0, 4'd0,  4'd0,  6'h00, 6'h00};
        tbl[5] = '{0, 0, 0, 0,  1, 0, 4'd15, 4'd0,  6'h01, 6'h01};
        tbl[6] = '{5, 0, 0, 0,  0, 6, 4'd0,  4'd0,  6'h01, 6'h01};
        tbl[7] = '{2, 0, 0, 5,  0, 2, 4'd5,  4'd5,  6'h01, 6'h01};
        tbl[8] = '{3, 0, 0, 7,  0, 3, 4'd7,  4'd7,  6'h01, 6'h01};
        tbl[9] = '{4, 0, 0, 15, 0, 4, 4'd15, 4'd15, 6'h01, 6'h01};

        cnt_clear = '0; cnt_inc = '0; cnt_dec = '0; ovf_clear = '0;
        rd_en = 1'b0; rd_sel = '0; snap_req = 1'b0;
        last_w = '0; last_s = '0;
        reset = 1'b1;
        tick();
        chk_ovf('0, '0);

        // Reset state, including out-of-range selects, read back-to-back.
        for (int c = 0; c < 8; c++) begin
            issue_read(c, 4'd0, 4'd0, 1'b1);
            tick();
        end
        tick();

        for (int k = 0; k < 10; k++) begin
            if (tbl[k].oclr) begin ovf_clear[tbl[k].ch] = 1'b1; tick(); end
            if (tbl[k].clr)  begin cnt_clear[tbl[k].ch] = 1'b1; tick(); end
            for (int n = 0; n < tbl[k].ninc; n++) begin cnt_inc[tbl[k].ch] = 1'b1; tick(); end
            for (int n = 0; n < tbl[k].ndec; n++) begin cnt_dec[tbl[k].ch] = 1'b1; tick(); end
            issue_read(tbl[k].rsel, tbl[k].ew, tbl[k].es, 1'b1);
            tick();
            chk_ovf(tbl[k].ovw, tbl[k].ovs);
        end

        // inc+dec together holds; clear beats inc.
        for (int n = 0; n < 3; n++) begin cnt_inc[2] = 1'b1; cnt_dec[2] = 1'b1; tick(); end
        issue_read(2, 4'd5, 4'd5, 1'b1);
        tick();
        cnt_clear[2] = 1'b1; cnt_inc[2] = 1'b1; tick();
        issue_read(2, 4'd0, 4'd0, 1'b1);
        tick();

        // Read returns the pre-update value of a same-cycle increment.
        cnt_inc[3] = 1'b1;
        issue_read(3, 4'd7, 4'd7, 1'b1);
        tick();
        issue_read(3, 4'd8, 4'd8, 1'b1);
        tick();

        // inc+dec at max raises no overflow.
        cnt_inc[4] = 1'b1; cnt_dec[4] = 1'b1; tick();
        issue_read(4, 4'd15, 4'd15, 1'b1);
        tick();
        chk_ovf(6'h01, 6'h01);

        // Overflow and ovf_clear in the same cycle: set wins.
        cnt_inc[4] = 1'b1; ovf_clear[4] = 1'b1; tick();
        issue_read(4, 4'd0, 4'd15, 1'b1);
        tick();
        chk_ovf(6'h11, 6'h11);

        // All channels update in one cycle.
        cnt_inc = '1; tick();
        chk_ovf(6'h11, 6'h13);
        issue_read(5, 4'd1, 4'd1, 1'b1);
        tick();
        issue_read(1, 4'd5, 4'd15, 1'b1);
        tick();
        tick();

        // Reset with a read in flight drops it.
        reset = 1'b1;
        issue_read(1, 4'd0, 4'd0, 1'b0);
        tick();
        chk_ovf('0, '0);
        issue_read(1, 4'd0, 4'd0, 1'b1);
        tick();

`ifdef PERF_CNT_SNAPSHOT_EN
        for (int n = 0; n < 9; n++) begin cnt_inc[0] = 1'b1; tick(); end
        snap_req = 1'b1; tick();
        for (int n = 0; n < 3; n++) begin cnt_inc[0] = 1'b1; tick(); end
        issue_read(0, 4'd9, 4'd9, 1'b0);
        tick();
        snap_req = 1'b1;
        issue_read(0, 4'd9, 4'd9, 1'b0);
        tick();
        issue_read(0, 4'd12, 4'd12, 1'b0);
        tick();
`endif

        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
